// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: widths, fetch states and jump-target table.
// The optional cycle counter is enabled with FETCH_CYCLE_CNT_EN.
package fetch_unit_pkg;

    localparam int PC_W      = 10;
    localparam int LUT_IDX_W = 5;
    localparam int OFF_W     = 6;
    localparam int CNT_W     = 16;
    localparam int LUT_DEPTH = 1 << LUT_IDX_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

    // Absolute jump targets; entry i holds (i+1)*16.
    localparam logic [PC_W-1:0] JUMP_LUT [LUT_DEPTH] = '{
        10'h010, 10'h020, 10'h030, 10'h040, 10'h050, 10'h060, 10'h070, 10'h080,
        10'h090, 10'h0A0, 10'h0B0, 10'h0C0, 10'h0D0, 10'h0E0, 10'h0F0, 10'h100,
        10'h110, 10'h120, 10'h130, 10'h140, 10'h150, 10'h160, 10'h170, 10'h180,
        10'h190, 10'h1A0, 10'h1B0, 10'h1C0, 10'h1D0, 10'h1E0, 10'h1F0, 10'h200
    };

endpackage

// File: rtl/fetch_unit_jump_lut.sv
// Combinational jump-target ROM indexed by the instruction's target field.
module jump_lut
    import fetch_unit_pkg::*;
(
    input  logic [LUT_IDX_W-1:0] target_idx,
    output logic [PC_W-1:0]      target
);

    assign target = JUMP_LUT[target_idx];

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer (IDLE/RUN/STALL/HALT).
// Define FETCH_CYCLE_CNT_EN to add the saturating cycle_cnt output.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic                 jump_en,
    input  logic                 branch_en,
    input  logic                 halt_in,
    input  logic                 stall_req,
    input  logic [LUT_IDX_W-1:0] target_idx,
    input  logic [OFF_W-1:0]     branch_off,
    output logic [PC_W-1:0]      instr_addr,
    output logic                 instr_valid,
    output logic                 done
`ifdef FETCH_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0]     cycle_cnt
`endif
);

    fetch_state_t    state;
    logic [PC_W-1:0] jump_target;
    logic [PC_W-1:0] branch_target;
    logic [PC_W-1:0] pc_inc;

    jump_lut u_jump_lut (
        .target_idx (target_idx),
        .target     (jump_target)
    );

    // Sign-extend the offset; the add wraps modulo 2^PC_W.
    assign branch_target = instr_addr + {{(PC_W-OFF_W){branch_off[OFF_W-1]}}, branch_off};
    assign pc_inc        = instr_addr + PC_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= S_IDLE;
            instr_addr  <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_RUN;
                        instr_addr  <= '0;
                        instr_valid <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (halt_in) begin
                        state       <= S_HALT;
                        instr_valid <= 1'b0;
                        done        <= 1'b1;
                    end else if (stall_req) begin
                        state       <= S_STALL;
                        instr_valid <= 1'b0;
                    end else if (jump_en) begin
                        instr_addr  <= jump_target;
                    end else if (branch_en) begin
                        instr_addr  <= branch_target;
                    end else begin
                        instr_addr  <= pc_inc;
                    end
                end
                S_STALL: begin
                    // The stalled instruction completes; resume at the next one.
                    if (!stall_req) begin
                        state       <= S_RUN;
                        instr_addr  <= pc_inc;
                        instr_valid <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (start) begin
                        state       <= S_RUN;
                        instr_addr  <= '0;
                        instr_valid <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    instr_addr  <= '0;
                    instr_valid <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_CYCLE_CNT_EN
    logic start_accepted;
    assign start_accepted = start && ((state == S_IDLE) || (state == S_HALT));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cycle_cnt <= '0;
        end else if (start_accepted) begin
            cycle_cnt <= '0;
        end else if (((state == S_RUN) || (state == S_STALL)) && (cycle_cnt != '1)) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a cycle model pushes expected outputs, sampled 1ns after each edge.
module tb_fetch_unit;

    localparam int ST_IDLE  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_STALL = 2;
    localparam int ST_HALT  = 3;

    typedef struct {
        logic [9:0]  addr;
        logic        valid;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    logic        Clk;
    logic        Reset;
    logic        start;
    logic        jump_en;
    logic        branch_en;
    logic        halt_in;
    logic        stall_req;
    logic [4:0]  target_idx;
    logic [5:0]  branch_off;
    logic [9:0]  instr_addr;
    logic        instr_valid;
    logic        done;
`ifdef FETCH_CYCLE_CNT_EN
    logic [15:0] cycle_cnt;
`endif

    int total = 0;
    int bad   = 0;

    int          m_state;
    logic [9:0]  m_pc;
    int          m_cnt;
    exp_t        sb_q[$];

    fetch_unit dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .start       (start),
        .jump_en     (jump_en),
        .branch_en   (branch_en),
        .halt_in     (halt_in),
        .stall_req   (stall_req),
        .target_idx  (target_idx),
        .branch_off  (branch_off),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .done        (done)
`ifdef FETCH_CYCLE_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [9:0] lut_ref(input logic [4:0] idx);
        return 10'((int'(idx) + 1) * 16);
    endfunction

    task automatic drive(input logic st, input logic j, input logic b, input logic h,
                         input logic s, input logic [4:0] idx, input logic [5:0] off);
        start = st; jump_en = j; branch_en = b; halt_in = h; stall_req = s;
        target_idx = idx; branch_off = off;
    endtask

    task automatic model_reset();
        m_state = ST_IDLE;
        m_pc    = '0;
        m_cnt   = 0;
    endtask

    // Advance the reference model by one clock using the currently driven inputs.
    task automatic model_step();
        int   off_i;
        int   n_state;
        logic [9:0] n_pc;
        int   n_cnt;
        n_state = m_state;
        n_pc    = m_pc;
        n_cnt   = m_cnt;
        off_i   = branch_off[5] ? int'(branch_off) - 64 : int'(branch_off);
        if ((m_state == ST_RUN || m_state == ST_STALL) && m_cnt < 65535) n_cnt = m_cnt + 1;
        case (m_state)
            ST_IDLE: if (start) begin n_state = ST_RUN; n_pc = '0; n_cnt = 0; end
            ST_RUN: begin
                if (halt_in)        n_state = ST_HALT;
                else if (stall_req) n_state = ST_STALL;
                else if (jump_en)   n_pc = lut_ref(target_idx);
                else if (branch_en) n_pc = 10'((int'(m_pc) + off_i + 1024) % 1024);
                else                n_pc = 10'((int'(m_pc) + 1) % 1024);
            end
            ST_STALL: if (!stall_req) begin n_state = ST_RUN; n_pc = 10'((int'(m_pc) + 1) % 1024); end
            default: if (start) begin n_state = ST_RUN; n_pc = '0; n_cnt = 0; end
        endcase
        m_state = n_state;
        m_pc    = n_pc;
        m_cnt   = n_cnt;
    endtask

    // One clock: push the model's expectation, then pop and compare after the edge.
    task automatic step(input string tag);
        exp_t e;
        exp_t got;
        model_step();
        e.addr  = m_pc;
        e.valid = (m_state == ST_RUN);
        e.done  = (m_state == ST_HALT);
        e.cnt   = 16'(m_cnt);
        sb_q.push_back(e);
        @(posedge Clk);
        #1;
        got = sb_q.pop_front();
        total++;
        if (instr_addr !== got.addr) begin
            bad++;
            $display("FAIL %s addr: got %h want %h", tag, instr_addr, got.addr);
        end
        total++;
        if (instr_valid !== got.valid) begin
            bad++;
            $display("FAIL %s valid: got %b want %b", tag, instr_valid, got.valid);
        end
        total++;
        if (done !== got.done) begin
            bad++;
            $display("FAIL %s done: got %b want %b", tag, done, got.done);
        end
`ifdef FETCH_CYCLE_CNT_EN
        total++;
        if (cycle_cnt !== got.cnt) begin
            bad++;
            $display("FAIL %s cnt: got %0d want %0d", tag, cycle_cnt, got.cnt);
        end
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
    endtask

    task automatic expect_addr(input string tag, input logic [9:0] want);
        total++;
        if (instr_addr !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, instr_addr, want);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        total++;
        if ({instr_addr, instr_valid, done} !== 12'd0) begin
            bad++;
            $display("FAIL reset_state: got %h/%b/%b want 000/0/0", instr_addr, instr_valid, done);
        end
        Reset = 1'b0;
        step("idle_hold");
    endtask

    task automatic test_sequential();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
        step("start");
        total++;
        if (instr_valid !== 1'b1) begin
            bad++;
            $display("FAIL first_valid: got %b want 1", instr_valid);
        end
        for (int i = 1; i < 5; i++) begin
            step("seq");
            expect_addr("seq_addr", 10'(i));
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
        step("start_in_run");
    endtask

    task automatic test_jump();
        while (m_pc != 10'd7) step("to_7");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 6'd0);
        step("jump3");
        expect_addr("jump3_addr", 10'h040);
        step("post_jump");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 6'b000101);
        step("jump_and_branch");
        expect_addr("jump_wins", 10'h040);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 6'd0);
        step("jump31");
    endtask

    task automatic test_branch();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
        step("to_010");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 6'b111100);
        step("branch_m4");
        expect_addr("branch_m4_addr", 10'h00C);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 6'b110010);
        step("to_3fe");
        expect_addr("to_3fe_addr", 10'h3FE);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 6'b000101);
        step("branch_wrap");
        expect_addr("branch_wrap_addr", 10'h003);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 6'b111100);
        step("to_3ff");
        step("inc_wrap");
        expect_addr("inc_wrap_addr", 10'h000);
    endtask

    task automatic test_stall();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 6'd0);
        step("to_020");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, i == 1, 1'b1, 5'd5, 6'd3);
            step("stall");
            expect_addr("stall_hold", 10'h020);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 6'd0);
        step("stall_exit");
        expect_addr("stall_exit_addr", 10'h021);
    endtask

    task automatic test_halt();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 6'b110100);
        step("to_015");
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 6'd0);
        step("halt");
        total++;
        if (done !== 1'b1 || instr_addr !== 10'h015) begin
            bad++;
            $display("FAIL halt_state: got done=%b addr=%h want 1/015", done, instr_addr);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, i[0], 5'd2, 6'd1);
            step("halt_hold");
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
        step("restart");
        expect_addr("restart_addr", 10'h000);
`ifdef FETCH_CYCLE_CNT_EN
        total++;
        if (cycle_cnt !== 16'd0) begin
            bad++;
            $display("FAIL restart_cnt: got %0d want 0", cycle_cnt);
        end
`endif
        step("after_restart");
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 6'd0);
        step("to_030");
        while (m_pc != 10'h033) step("to_033");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 6'd0);
        step("enter_stall");
        stall_req = 1'b1;
        #2;
        Reset = 1'b1;
        #1;
        total++;
        if ({instr_addr, instr_valid, done} !== 12'd0) begin
            bad++;
            $display("FAIL async_reset: got %h/%b/%b want 000/0/0", instr_addr, instr_valid, done);
        end
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        stall_req = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) step("idle_after_reset");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0);
        step("start_after_reset");
        step("run_after_reset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, i % 3 == 0, i % 2 == 0, 1'b0, 1'b0, 5'(i * 5), 6'(i * 11));
            step("b2b");
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump();
        test_branch();
        test_stall();
        test_halt();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
